// File: rtl/qea_ctrl_pkg.sv
// qea_ctrl_pkg: shared FSM state type, fixed-point unit and depth helper
package qea_ctrl_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_LD_CTX, S_LD_ST, S_START, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_FIN
    } state_t;

    // 1.0 at 30 fraction bits
    localparam logic [63:0] ONE_FXP = 64'd1 << 30;

    function automatic logic [63:0] depth_of(input int qbit_num, input int pe_num_width);
        return (qbit_num < pe_num_width) ? 64'd0 : 64'd1 << (qbit_num - pe_num_width);
    endfunction
endpackage

// File: rtl/qea_rd_hold.sv
// qea_rd_hold: delays a read issue by RD_LAT cycles, captures RAM data and
// presents it on a valid/ready port until accepted.
module qea_rd_hold #(
    parameter int W      = 256,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue,
    input  logic         ready,
    input  logic [W-1:0] dout,
    output logic         cap,
    output logic         valid,
    output logic [W-1:0] word
);
    logic [RD_LAT-1:0] pipe;

    assign cap = pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe  <= '0;
            valid <= 1'b0;
            word  <= '0;
        end else begin
            pipe <= RD_LAT'({pipe, issue});
            if (cap) begin
                valid <= 1'b1;
                word  <= dout;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/qea_run_controller.sv
// qea_run_controller: runs one QEA command end to end: context load, state
// init, start/run with timeout, and optional state readout.
module qea_run_controller
    import qea_ctrl_pkg::*;
#(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int CTX_DATA_WIDTH   = 64,
    parameter int CTX_ADDR_WIDTH   = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int RD_LAT           = 1,
    parameter int TIMEOUT_CYCLES   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_cmd_valid,
    output logic                               o_cmd_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_cmd_qbit_num,
    input  logic [CTX_ADDR_WIDTH:0]            i_cmd_ins_num,
    input  logic                               i_cmd_state_mode,
    input  logic                               i_cmd_readout,
    input  logic                               i_ctx_valid,
    output logic                               o_ctx_ready,
    input  logic [CTX_DATA_WIDTH-1:0]          i_ctx_word,
    input  logic                               i_st_valid,
    output logic                               o_st_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_st_word,
    output logic                               o_rd_valid,
    input  logic                               i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_rd_word,
    output logic                               o_rd_last,
    output logic                               o_qea_ctx_en,
    output logic                               o_qea_ctx_wea,
    output logic [CTX_ADDR_WIDTH-1:0]          o_qea_ctx_addr,
    output logic [CTX_DATA_WIDTH-1:0]          o_qea_ctx_data,
    output logic [PE_NUM-1:0]                  o_qea_state_ena,
    output logic [PE_NUM-1:0]                  o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_qea_state_dina,
    output logic                               o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num,
    input  logic                               i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_qea_state_dout,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_err_cfg,
    output logic                               o_err_timeout,
    output logic [31:0]                        o_cycle_count
);
    localparam int SW = PE_NUM * STATE_DATA_WIDTH;
    // rescale the 30-fraction-bit unit to NUM_FRAC_BIT
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'((ONE_FXP >> 30) << NUM_FRAC_BIT);
    localparam logic [SW-1:0] INIT0 = {ONE, {(SW-DATA_WIDTH){1'b0}}};
    localparam logic [CTX_ADDR_WIDTH:0] INS_MAX = {1'b1, {CTX_ADDR_WIDTH{1'b0}}};

    state_t state, nxt;
    logic mode, rdo, cfg_bad, rd_iss, rd_hs, cap, ptr_last, ctx_last, to_hit;
    logic [63:0] depth;
    logic [CTX_ADDR_WIDTH-1:0] ins_last, cnt;
    logic [STATE_ADDR_WIDTH-1:0] last, ptr;

    assign depth    = depth_of(int'(i_cmd_qbit_num), PE_NUM_WIDTH);
    assign cfg_bad  = int'(i_cmd_qbit_num) < PE_NUM_WIDTH
                   || int'(i_cmd_qbit_num) - PE_NUM_WIDTH > STATE_ADDR_WIDTH
                   || i_cmd_ins_num > INS_MAX;
    assign ptr_last = ptr == last;
    assign ctx_last = cnt == ins_last;
    assign to_hit   = TIMEOUT_CYCLES != 0 && o_cycle_count == 32'(TIMEOUT_CYCLES - 1);
    assign rd_hs    = state == S_RD_OUT && i_rd_ready;
    assign o_cmd_ready = state == S_IDLE;
    assign o_busy      = state != S_IDLE;
    assign o_rd_last   = o_rd_valid && ptr_last;

    qea_rd_hold #(.W(SW), .RD_LAT(RD_LAT)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .issue (rd_iss),
        .ready (rd_hs),
        .dout  (i_qea_state_dout),
        .cap   (cap),
        .valid (o_rd_valid),
        .word  (o_rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            o_qea_qbit_num <= '0;
            mode           <= 1'b0;
            rdo            <= 1'b0;
            ins_last       <= '0;
            last           <= '0;
            cnt            <= '0;
            ptr            <= '0;
            o_err_cfg      <= 1'b0;
            o_err_timeout  <= 1'b0;
            o_cycle_count  <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && i_cmd_valid) begin
                o_qea_qbit_num <= i_cmd_qbit_num;
                mode           <= i_cmd_state_mode;
                rdo            <= i_cmd_readout;
                ins_last       <= CTX_ADDR_WIDTH'(i_cmd_ins_num - 1'b1);
                last           <= STATE_ADDR_WIDTH'(depth - 64'd1);
                cnt            <= '0;
                ptr            <= '0;
                o_err_cfg      <= cfg_bad;
                o_err_timeout  <= 1'b0;
            end
            if (o_qea_ctx_en) cnt <= cnt + 1'b1;
            if (o_qea_state_wea[0] || rd_hs) ptr <= ptr + 1'b1;
            if (state == S_START) begin
                ptr           <= '0;
                o_cycle_count <= '0;
            end
            if (state == S_RUN) begin
                if (~&o_cycle_count) o_cycle_count <= o_cycle_count + 1'b1;
                if (!i_qea_complete && to_hit) o_err_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt               = state;
        o_ctx_ready       = 1'b0;
        o_st_ready        = 1'b0;
        o_qea_ctx_en      = 1'b0;
        o_qea_ctx_wea     = 1'b0;
        o_qea_ctx_addr    = '0;
        o_qea_ctx_data    = '0;
        o_qea_state_ena   = '0;
        o_qea_state_wea   = '0;
        o_qea_state_addra = '0;
        o_qea_state_dina  = '0;
        o_qea_start       = 1'b0;
        o_done            = 1'b0;
        rd_iss            = 1'b0;
        case (state)
            S_IDLE: if (i_cmd_valid) nxt = cfg_bad ? S_FIN : (i_cmd_ins_num == '0 ? S_LD_ST : S_LD_CTX);
            S_LD_CTX: begin
                o_ctx_ready = 1'b1;
                if (i_ctx_valid) begin
                    o_qea_ctx_en   = 1'b1;
                    o_qea_ctx_wea  = 1'b1;
                    o_qea_ctx_addr = cnt;
                    o_qea_ctx_data = i_ctx_word;
                    if (ctx_last) nxt = S_LD_ST;
                end
            end
            S_LD_ST: begin
                o_st_ready = mode;
                if (!mode || i_st_valid) begin
                    o_qea_state_ena   = '1;
                    o_qea_state_wea   = '1;
                    o_qea_state_addra = ptr;
                    o_qea_state_dina  = mode ? i_st_word : (ptr == '0 ? INIT0 : '0);
                    if (ptr_last) nxt = S_START;
                end
            end
            S_START: begin
                o_qea_start = 1'b1;
                nxt = S_RUN;
            end
            S_RUN: if (i_qea_complete) nxt = rdo ? S_RD_ISSUE : S_FIN; else if (to_hit) nxt = S_FIN;
            S_RD_ISSUE: begin
                o_qea_state_ena   = '1;
                o_qea_state_addra = ptr;
                rd_iss = 1'b1;
                nxt = S_RD_WAIT;
            end
            S_RD_WAIT: if (cap) nxt = S_RD_OUT;
            S_RD_OUT: if (i_rd_ready) nxt = ptr_last ? S_FIN : S_RD_ISSUE;
            S_FIN: begin
                o_done = 1'b1;
                nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_qea_run_controller.sv
// tb_qea_run_controller: directed checks of load/run/readout, timeout,
// config error and mid-operation reset against hand-computed values.
module tb_qea_run_controller;
    localparam int SW = 256;

    logic clk = 1'b0, rst = 1'b1;
    logic i_cmd_valid = 0, o_cmd_ready;
    logic [5:0] i_cmd_qbit_num = 0;
    logic [16:0] i_cmd_ins_num = 0;
    logic i_cmd_state_mode = 0, i_cmd_readout = 0;
    logic i_ctx_valid = 0, o_ctx_ready;
    logic [63:0] i_ctx_word = 0;
    logic i_st_valid = 0, o_st_ready;
    logic [SW-1:0] i_st_word = 0;
    logic o_rd_valid, i_rd_ready = 0, o_rd_last;
    logic [SW-1:0] o_rd_word;
    logic o_qea_ctx_en, o_qea_ctx_wea;
    logic [15:0] o_qea_ctx_addr;
    logic [63:0] o_qea_ctx_data;
    logic [3:0] o_qea_state_ena, o_qea_state_wea;
    logic [15:0] o_qea_state_addra;
    logic [SW-1:0] o_qea_state_dina, i_qea_state_dout;
    logic o_qea_start, i_qea_complete = 0;
    logic [5:0] o_qea_qbit_num;
    logic o_busy, o_done, o_err_cfg, o_err_timeout;
    logic [31:0] o_cycle_count;

    always #5 clk = ~clk;

    qea_run_controller #(.RD_LAT(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_qbit_num(i_cmd_qbit_num), .i_cmd_ins_num(i_cmd_ins_num),
        .i_cmd_state_mode(i_cmd_state_mode), .i_cmd_readout(i_cmd_readout),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_word(i_ctx_word),
        .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_word(i_st_word),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_word(o_rd_word), .o_rd_last(o_rd_last),
        .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
        .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
        .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
        .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout),
        .o_busy(o_busy), .o_done(o_done), .o_err_cfg(o_err_cfg),
        .o_err_timeout(o_err_timeout), .o_cycle_count(o_cycle_count)
    );

    // state RAM with a 2-cycle read latency
    logic [SW-1:0] mem [16];
    logic [SW-1:0] p0, p1;
    always @(posedge clk) begin
        if (o_qea_state_ena[0] && o_qea_state_wea[0]) mem[o_qea_state_addra[3:0]] <= o_qea_state_dina;
        if (o_qea_state_ena[0]) p0 <= mem[o_qea_state_addra[3:0]];
        p1 <= p0;
    end
    assign i_qea_state_dout = p1;

    int n_ctx = 0, ctx_bad = 0, ctx_exp = 0, n_wr = 0, n_rd = 0, n_start = 0, n_done = 0, n_valid = 0, wr_in_rd = 0;
    bit rd_phase = 0;
    logic [SW-1:0] init0 = '0;
    always @(negedge clk) begin
        if (o_qea_ctx_en) begin
            if (!o_qea_ctx_wea || o_qea_ctx_addr != ctx_exp[15:0] || o_qea_ctx_data != {48'hC0DE_0000_0000, ctx_exp[15:0]}) ctx_bad++;
            ctx_exp++;
            n_ctx++;
        end
        if (o_qea_state_wea[0]) n_wr++;
        if (o_qea_state_wea[0] && o_qea_state_addra == 16'd0) init0 = o_qea_state_dina;
        if (o_qea_state_ena[0] && !o_qea_state_wea[0]) n_rd++;
        if (rd_phase && o_qea_state_wea != 4'd0) wr_in_rd++;
        if (o_qea_start) n_start++;
        if (o_done) n_done++;
        if (o_rd_valid) n_valid++;
    end

    int n_pass = 0, n_chk = 0;
    logic [SW-1:0] exp_rd [4];

    task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] stw(input int i);
        return {8{8'(i + 1), 24'h3C5A96}};
    endfunction

    task automatic send_cmd(input int q, input int ins, input logic mode, input logic rdo);
        chk("cmd_ready", o_cmd_ready, 1'b1);
        i_cmd_qbit_num = 6'(q);
        i_cmd_ins_num = 17'(ins);
        i_cmd_state_mode = mode;
        i_cmd_readout = rdo;
        i_cmd_valid = 1;
        ctx_exp = 0;
        tick;
        i_cmd_valid = 0;
    endtask

    task automatic feed_ctx(input int n, input bit toggle);
        int i = 0, k = 0;
        logic acc;
        while (i < n && k < 2000) begin
            i_ctx_valid = toggle ? (k % 2 == 0) : 1'b1;
            i_ctx_word = {48'hC0DE_0000_0000, 16'(i)};
            acc = i_ctx_valid && o_ctx_ready;
            tick;
            if (acc) i++;
            k++;
        end
        i_ctx_valid = 0;
        chk("ctx_fed", i, n);
    endtask

    task automatic feed_st(input int n);
        int i = 0, k = 0;
        logic acc;
        while (i < n && k < 200) begin
            i_st_valid = 1;
            i_st_word = stw(i);
            acc = o_st_ready;
            tick;
            if (acc) i++;
            k++;
        end
        i_st_valid = 0;
        chk("st_fed", i, n);
    endtask

    task automatic wait_start;
        int k = 0;
        while (!o_qea_start && k < 300) begin
            tick;
            k++;
        end
        chk("start_seen", o_qea_start, 1'b1);
    endtask

    task automatic run(input int n);
        tick;
        repeat (n - 1) tick;
        i_qea_complete = 1;
        tick;
        i_qea_complete = 0;
        rd_phase = 1;
    endtask

    task automatic readout(input int n);
        int k, r;
        for (int w = 0; w < n; w++) begin
            k = 0;
            while (!o_rd_valid && k < 50) begin
                tick;
                k++;
            end
            chk($sformatf("rd_word%0d", w), o_rd_word, exp_rd[w]);
            chk($sformatf("rd_last%0d", w), o_rd_last, w == n - 1);
            if (w == 1) begin
                r = n_rd;
                repeat (5) begin
                    tick;
                    chk("bp_valid", o_rd_valid, 1'b1);
                    chk("bp_word", o_rd_word, exp_rd[w]);
                end
                chk("bp_no_read", n_rd, r);
            end
            i_rd_ready = 1;
            tick;
            i_rd_ready = 0;
        end
    endtask

    task automatic wait_done;
        int k = 0;
        while (!o_done && k < 300) begin
            tick;
            k++;
        end
        chk("done_seen", o_done, 1'b1);
        tick;
        chk("done_pulse", o_done, 1'b0);
        chk("idle_after", o_busy, 1'b0);
        rd_phase = 0;
    endtask

    initial begin
        int c0, w0, r0, s0, d0, v0;
        repeat (3) tick;
        chk("rst_cmd_ready", o_cmd_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_start", o_qea_start, 1'b0);
        chk("rst_cycles", o_cycle_count, 32'd0);
        chk("rst_ctx_en", o_qea_ctx_en, 1'b0);
        chk("rst_ena", o_qea_state_ena, 4'd0);
        chk("rst_errs", {o_err_cfg, o_err_timeout}, 2'b00);
        chk("rst_rd_valid", o_rd_valid, 1'b0);
        rst = 0;
        tick;

        // basic run with toggling context valid and readout backpressure
        send_cmd(4, 151, 0, 1);
        chk("qbit_reg", o_qea_qbit_num, 6'd4);
        feed_ctx(151, 1);
        wait_start;
        run(40);
        chk("cycles_40", o_cycle_count, 32'd40);
        exp_rd[0] = {64'h4000_0000_0000_0000, 192'd0};
        exp_rd[1] = '0;
        exp_rd[2] = '0;
        exp_rd[3] = '0;
        readout(4);
        wait_done;
        chk("ctx_count", n_ctx, 151);
        chk("ctx_contig", ctx_bad, 0);
        chk("st_writes", n_wr, 4);
        chk("init_word", init0, {64'h4000_0000_0000_0000, 192'd0});
        chk("starts", n_start, 1);
        chk("dones", n_done, 1);
        chk("reads", n_rd, 4);
        chk("no_wr_in_rd", wr_in_rd, 0);

        // timeout with complete never asserted, no context words
        c0 = n_ctx; w0 = n_wr; v0 = n_valid; d0 = n_done;
        send_cmd(2, 0, 0, 1);
        wait_start;
        begin
            int k = 0;
            while (!o_done && k < 300) begin
                tick;
                k++;
            end
        end
        chk("to_done", o_done, 1'b1);
        chk("to_err", o_err_timeout, 1'b1);
        chk("to_cycles", o_cycle_count, 32'd100);
        tick;
        chk("to_no_readout", n_valid, v0);
        chk("to_ctx", n_ctx, c0);
        chk("to_wr", n_wr, w0 + 1);
        chk("to_dones", n_done, d0 + 1);

        // config error: too few qubits
        c0 = n_ctx; w0 = n_wr; r0 = n_rd; s0 = n_start;
        send_cmd(1, 5, 0, 1);
        chk("cfg_done", o_done, 1'b1);
        chk("cfg_err", o_err_cfg, 1'b1);
        chk("cfg_to_cleared", o_err_timeout, 1'b0);
        tick;
        chk("cfg_done_drop", o_done, 1'b0);
        chk("cfg_idle", o_cmd_ready, 1'b1);
        chk("cfg_no_strobes", {n_ctx - c0, n_wr - w0, n_rd - r0, n_start - s0}, '0);

        // reset during streamed state load
        send_cmd(4, 2, 1, 1);
        chk("err_cleared", o_err_cfg, 1'b0);
        feed_ctx(2, 0);
        feed_st(2);
        i_st_valid = 1;
        i_st_word = stw(2);
        #1;
        chk("pre_rst_wea", o_qea_state_wea, 4'hF);
        rst = 1;
        #1;
        chk("rst_mid_ena", o_qea_state_ena, 4'd0);
        chk("rst_mid_wea", o_qea_state_wea, 4'd0);
        chk("rst_mid_st_ready", o_st_ready, 1'b0);
        chk("rst_mid_cmd_ready", o_cmd_ready, 1'b1);
        chk("rst_mid_busy", o_busy, 1'b0);
        i_st_valid = 0;
        tick;
        rst = 0;
        tick;

        // clean streamed run after the reset
        w0 = n_wr; r0 = n_rd;
        send_cmd(4, 0, 1, 1);
        feed_st(4);
        wait_start;
        run(5);
        chk("cycles_5", o_cycle_count, 32'd5);
        for (int i = 0; i < 4; i++) exp_rd[i] = stw(i);
        readout(4);
        wait_done;
        chk("st2_writes", n_wr, w0 + 4);
        chk("st2_reads", n_rd, r0 + 4);
        chk("no_wr_in_rd2", wr_in_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
